// File: rtl/led_sopc_jtag_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug bridge.
// Holds the default IR/shift-register widths, the command entry layout
// {ch, sr}, the position of the action bit inside sr, and the channel
// indices used by the debug core when decoding take_action pulses.
package led_sopc_jtag_dbg_pkg;

  localparam int unsigned IR_W_DEF   = 2;
  localparam int unsigned SR_W_DEF   = 38;
  localparam int unsigned ACTION_BIT = SR_W_DEF - 1;

  // Queued command at default widths: channel in the upper bits, payload below.
  typedef struct packed {
    logic [IR_W_DEF-1:0] ch;
    logic [SR_W_DEF-1:0] sr;
  } cmd_entry_t;

  // Channel indices; A/B/C variants share a channel and are told apart by jdo bits.
  localparam logic [IR_W_DEF-1:0] OCIMEM_A   = IR_W_DEF'(0);
  localparam logic [IR_W_DEF-1:0] OCIMEM_B   = IR_W_DEF'(0);
  localparam logic [IR_W_DEF-1:0] TRACEMEM_A = IR_W_DEF'(1);
  localparam logic [IR_W_DEF-1:0] TRACEMEM_B = IR_W_DEF'(1);
  localparam logic [IR_W_DEF-1:0] BREAK_A    = IR_W_DEF'(2);
  localparam logic [IR_W_DEF-1:0] BREAK_B    = IR_W_DEF'(2);
  localparam logic [IR_W_DEF-1:0] BREAK_C    = IR_W_DEF'(2);
  localparam logic [IR_W_DEF-1:0] TRACECTRL  = IR_W_DEF'(3);

endpackage

// File: rtl/led_sopc_jtag_debug_cmd_sysclk_if.sv
// Command channel between the sysclk bridge (master) and the debug core (slave).
//   cmd_valid/cmd_ready : head-of-queue handshake
//   cmd_ir              : channel of the head command
//   jdo                 : payload of the most recently popped command
//   take_action / take_no_action : one-cycle per-channel pulses on pop
interface led_sopc_jtag_debug_cmd_sysclk_if #(
  parameter int unsigned IR_W = led_sopc_jtag_dbg_pkg::IR_W_DEF,
  parameter int unsigned SR_W = led_sopc_jtag_dbg_pkg::SR_W_DEF
);
  localparam int unsigned NCH = 1 << IR_W;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action;
  logic [NCH-1:0]  take_no_action;

  modport master (
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
    output cmd_ready
  );
endinterface

// File: rtl/led_sopc_jtag_strobe_sync.sv
// Brings a TCK-domain level strobe into clk and emits a registered one-cycle
// pulse per rising edge. The pulse is high SYNC_STAGES+1 edges after the
// strobe is first sampled.
//   clk, reset_n : system clock, async active-low reset
//   strobe       : asynchronous level input
//   pulse        : one-cycle pulse per rising edge of strobe
module led_sopc_jtag_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   pulse_q, pulse_d;

  // Shift chain, edge history and rising-edge detect.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], strobe};
    edge_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/led_sopc_jtag_debug_cmd_sysclk.sv
// System-clock half of the JTAG debug bridge. Synchronises the update-IR and
// update-DR strobes, latches the IR, queues each DR update as a {ch, sr}
// command and hands commands to the debug core under valid/ready.
//   clk, reset_n      : system clock, async active-low reset
//   vs_uir, vs_udr    : TCK-domain update strobes (asynchronous)
//   ir_in, sr         : TCK-domain IR and shift register (quasi-static)
//   overflow_clr      : clears the sticky overflow flag
//   cmd_if (master)   : command handshake, jdo and per-channel pulses
//   ir_latched        : last captured IR
//   overflow          : a command was dropped on a full queue
//   fill              : queue occupancy
module led_sopc_jtag_debug_cmd_sysclk
  import led_sopc_jtag_dbg_pkg::*;
#(
  parameter int unsigned          IR_W        = IR_W_DEF,
  parameter int unsigned          SR_W        = SR_W_DEF,
  parameter int unsigned          DEPTH       = 4,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter logic [(1<<IR_W)-1:0] CH_MASK     = '1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     overflow_clr,
  led_sopc_jtag_debug_cmd_sysclk_if.master cmd_if,
  output logic [IR_W-1:0]          ir_latched,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned NCH = 1 << IR_W;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;

  typedef struct packed {
    logic [IR_W-1:0] ch;
    logic [SR_W-1:0] sr;
  } entry_t;

  logic uir_p, udr_p;

  led_sopc_jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_uir),
    .pulse   (uir_p)
  );

  led_sopc_jtag_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .strobe  (vs_udr),
    .pulse   (udr_p)
  );

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   fill_q, fill_d;
  logic            valid_q, valid_d;
  logic [IR_W-1:0] cmd_ir_q, cmd_ir_d;
  logic [IR_W-1:0] ir_latched_q, ir_latched_d;
  logic [SR_W-1:0] jdo_q, jdo_d;
  logic [NCH-1:0]  take_action_q, take_action_d;
  logic [NCH-1:0]  take_no_action_q, take_no_action_d;
  logic            overflow_q, overflow_d;

  logic [AW-1:0]   wr_idx, rd_idx;
  logic            empty, full, pop, wr_req, wr_en, drop;
  entry_t          head, new_entry;

  // Queue status; the wrap bit distinguishes full from empty.
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign head   = mem_q[rd_idx];

  // New entry uses the IR latched before this cycle, so a coincident
  // update-IR only affects later commands.
  assign new_entry = '{ch: ir_latched_q, sr: sr};
  assign wr_req    = udr_p & CH_MASK[ir_latched_q];
  assign pop       = ~empty & cmd_if.cmd_ready;
  assign wr_en     = wr_req & (~full | pop);
  assign drop      = wr_req & full & ~pop;

  // Next-state for queue, capture registers and pulse outputs.
  always_comb begin
    mem_d            = mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    ir_latched_d     = ir_latched_q;
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    overflow_d       = overflow_q;

    if (uir_p) begin
      ir_latched_d = ir_in;
    end

    if (wr_en) begin
      mem_d[wr_idx] = new_entry;
      wr_ptr_d      = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      jdo_d    = head.sr;
      if (head.sr[SR_W-1]) begin
        take_action_d[head.ch] = 1'b1;
      end else begin
        take_no_action_d[head.ch] = 1'b1;
      end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    fill_d   = wr_ptr_d - rd_ptr_d;
    valid_d  = (wr_ptr_d != rd_ptr_d);
    cmd_ir_d = mem_d[rd_ptr_d[AW-1:0]].ch;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fill_q           <= '0;
      valid_q          <= 1'b0;
      cmd_ir_q         <= '0;
      ir_latched_q     <= '0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overflow_q       <= 1'b0;
    end else begin
      mem_q            <= mem_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      fill_q           <= fill_d;
      valid_q          <= valid_d;
      cmd_ir_q         <= cmd_ir_d;
      ir_latched_q     <= ir_latched_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overflow_q       <= overflow_d;
    end
  end

  assign cmd_if.cmd_valid      = valid_q;
  assign cmd_if.cmd_ir         = cmd_ir_q;
  assign cmd_if.jdo            = jdo_q;
  assign cmd_if.take_action    = take_action_q;
  assign cmd_if.take_no_action = take_no_action_q;
  assign ir_latched            = ir_latched_q;
  assign overflow              = overflow_q;
  assign fill                  = fill_q;

endmodule

// File: tb/tb_led_sopc_jtag_debug_cmd_sysclk.sv
// Directed bench for the sysclk debug bridge: a full-mask DUT plus a second
// DUT with CH_MASK=4'b1101 that only sees strobes while sel_m is set.
module tb_led_sopc_jtag_debug_cmd_sysclk;

  logic        clk;
  logic        reset_n;
  logic        vs_uir, vs_udr;
  logic [1:0]  ir_in;
  logic [37:0] sr_v;
  logic        overflow_clr;
  logic        sel_m;
  logic        m_vs_uir, m_vs_udr;

  logic [1:0]  ir_latched, m_ir_latched;
  logic        overflow, m_overflow;
  logic [2:0]  fill, m_fill;

  int checks = 0;
  int errors = 0;

  led_sopc_jtag_debug_cmd_sysclk_if #(.IR_W(2), .SR_W(38)) cmd_if ();
  led_sopc_jtag_debug_cmd_sysclk_if #(.IR_W(2), .SR_W(38)) m_if ();

  assign m_vs_uir        = sel_m & vs_uir;
  assign m_vs_udr        = sel_m & vs_udr;
  assign m_if.cmd_ready  = cmd_if.cmd_ready;

  led_sopc_jtag_debug_cmd_sysclk #(
    .IR_W(2), .SR_W(38), .DEPTH(4), .SYNC_STAGES(2), .CH_MASK(4'b1111)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr_v), .overflow_clr(overflow_clr), .cmd_if(cmd_if),
    .ir_latched(ir_latched), .overflow(overflow), .fill(fill)
  );

  led_sopc_jtag_debug_cmd_sysclk #(
    .IR_W(2), .SR_W(38), .DEPTH(4), .SYNC_STAGES(2), .CH_MASK(4'b1101)
  ) dut_m (
    .clk(clk), .reset_n(reset_n), .vs_uir(m_vs_uir), .vs_udr(m_vs_udr),
    .ir_in(ir_in), .sr(sr_v), .overflow_clr(overflow_clr), .cmd_if(m_if),
    .ir_latched(m_ir_latched), .overflow(m_overflow), .fill(m_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ir(input logic [1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    tick(5);
    vs_uir = 1'b0;
    tick(4);
  endtask

  task automatic do_dr(input logic [37:0] v);
    sr_v   = v;
    vs_udr = 1'b1;
    tick(5);
    vs_udr = 1'b0;
    tick(4);
  endtask

  initial begin
    reset_n          = 1'b0;
    vs_uir           = 1'b0;
    vs_udr           = 1'b0;
    ir_in            = 2'b00;
    sr_v             = '0;
    overflow_clr     = 1'b0;
    sel_m            = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    tick(3);

    // Reset values
    check("rst_valid",  64'(cmd_if.cmd_valid),      64'd0);
    check("rst_cmd_ir", 64'(cmd_if.cmd_ir),         64'd0);
    check("rst_jdo",    64'(cmd_if.jdo),            64'd0);
    check("rst_ta",     64'(cmd_if.take_action),    64'd0);
    check("rst_tna",    64'(cmd_if.take_no_action), 64'd0);
    check("rst_irl",    64'(ir_latched),            64'd0);
    check("rst_ovf",    64'(overflow),              64'd0);
    check("rst_fill",   64'(fill),                  64'd0);
    reset_n = 1'b1;
    tick(2);

    // Basic action on channel 1; masked DUT must ignore it
    cmd_if.cmd_ready = 1'b1;
    sel_m = 1'b1;
    do_ir(2'b01);
    check("irl_1",   64'(ir_latched),   64'd1);
    check("m_irl_1", 64'(m_ir_latched), 64'd1);
    sr_v   = 38'h20_0000_00AB;
    vs_udr = 1'b1;
    tick(3);
    check("lat_valid_early", 64'(cmd_if.cmd_valid), 64'd0);
    tick(1);
    check("basic_valid", 64'(cmd_if.cmd_valid), 64'd1);
    check("basic_cmdir", 64'(cmd_if.cmd_ir),    64'd1);
    check("basic_fill",  64'(fill),             64'd1);
    check("m_fill",      64'(m_fill),           64'd0);
    check("m_valid",     64'(m_if.cmd_valid),   64'd0);
    tick(1);
    check("basic_valid_pop", 64'(cmd_if.cmd_valid),      64'd0);
    check("basic_ta",        64'(cmd_if.take_action),    64'h2);
    check("basic_tna",       64'(cmd_if.take_no_action), 64'd0);
    check("basic_jdo",       64'(cmd_if.jdo),            64'h20_0000_00AB);
    check("m_ta",            64'(m_if.take_action),      64'd0);
    check("m_tna",           64'(m_if.take_no_action),   64'd0);
    tick(1);
    check("basic_ta_end", 64'(cmd_if.take_action), 64'd0);
    check("basic_jdo_hold", 64'(cmd_if.jdo),       64'h20_0000_00AB);
    vs_udr = 1'b0;
    tick(4);
    check("m_ovf",    64'(m_overflow),   64'd0);
    check("m_jdo",    64'(m_if.jdo),     64'd0);
    check("m_cmdir",  64'(m_if.cmd_ir),  64'd0);
    sel_m = 1'b0;

    // No-action path on channel 3
    do_ir(2'b11);
    sr_v   = 38'h00_1234_5678;
    vs_udr = 1'b1;
    tick(4);
    check("na_valid", 64'(cmd_if.cmd_valid), 64'd1);
    check("na_cmdir", 64'(cmd_if.cmd_ir),    64'd3);
    tick(1);
    check("na_tna", 64'(cmd_if.take_no_action), 64'h8);
    check("na_ta",  64'(cmd_if.take_action),    64'd0);
    check("na_jdo", 64'(cmd_if.jdo),            64'h1234_5678);
    vs_udr = 1'b0;
    tick(4);

    // Backpressure: five updates into a four-entry queue
    cmd_if.cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) do_dr(38'(i));
    check("bp_fill",  64'(fill),             64'd4);
    check("bp_ovf",   64'(overflow),         64'd1);
    check("bp_valid", 64'(cmd_if.cmd_valid), 64'd1);
    cmd_if.cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("bp_jdo", 64'(cmd_if.jdo),            64'(i));
      check("bp_tna", 64'(cmd_if.take_no_action), 64'h8);
    end
    tick(1);
    check("bp_tna_end",  64'(cmd_if.take_no_action), 64'd0);
    check("bp_fill_end", 64'(fill),                  64'd0);
    check("bp_valid_end", 64'(cmd_if.cmd_valid),     64'd0);
    check("bp_jdo_end",  64'(cmd_if.jdo),            64'd4);
    cmd_if.cmd_ready = 1'b0;

    // Overflow clear
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 64'(overflow), 64'd0);

    // Full queue with write and pop in the same cycle
    for (int i = 6; i <= 9; i++) do_dr(38'(i));
    check("full_fill", 64'(fill),     64'd4);
    check("full_ovf",  64'(overflow), 64'd0);
    sr_v   = 38'd10;
    vs_udr = 1'b1;
    tick(3);
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    cmd_if.cmd_ready = 1'b0;
    check("wp_fill", 64'(fill),                  64'd4);
    check("wp_ovf",  64'(overflow),              64'd0);
    check("wp_jdo",  64'(cmd_if.jdo),            64'd6);
    check("wp_tna",  64'(cmd_if.take_no_action), 64'h8);
    tick(1);
    check("wp_fill2", 64'(fill), 64'd4);
    cmd_if.cmd_ready = 1'b1;
    tick(1);
    cmd_if.cmd_ready = 1'b0;
    check("wp_jdo2", 64'(cmd_if.jdo), 64'd7);
    vs_udr = 1'b0;
    tick(4);
    check("pre_rst_fill", 64'(fill), 64'd3);

    // Asynchronous reset with three commands queued
    reset_n = 1'b0;
    #1;
    check("arst_fill",  64'(fill),             64'd0);
    check("arst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    check("arst_jdo",   64'(cmd_if.jdo),       64'd0);
    check("arst_irl",   64'(ir_latched),       64'd0);
    check("arst_ovf",   64'(overflow),         64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Drop coinciding with overflow_clr keeps overflow set
    for (int i = 1; i <= 4; i++) do_dr(38'(32'h11 + i));
    check("race_fill", 64'(fill),     64'd4);
    check("race_ovf0", 64'(overflow), 64'd0);
    sr_v   = 38'h55;
    vs_udr = 1'b1;
    tick(3);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("race_ovf",   64'(overflow), 64'd1);
    check("race_fill2", 64'(fill),     64'd4);
    vs_udr = 1'b0;
    tick(4);
    cmd_if.cmd_ready = 1'b1;
    tick(4);
    check("race_jdo_last", 64'(cmd_if.jdo), 64'h15);
    tick(1);
    cmd_if.cmd_ready = 1'b0;
    check("race_valid_end", 64'(cmd_if.cmd_valid), 64'd0);
    check("race_jdo_hold",  64'(cmd_if.jdo),       64'h15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
